inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the processor's decode/execute core. Holds the 16-word instruction memory (runtime-loadable), keeps the program counter, and streams 32-bit instruction words plus their PC to decode through a 2-entry prefetch queue with a valid/ready handshake. Jump redirects from execute flush in-flight work; halt from execute freezes fetching until reset.

---
 rtl/inst_fetch_pkg.sv | 25 ++
 rtl/inst_fetch_queue.sv | 44 ++++
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: state encoding,
// width defaults and control opcodes.
package inst_fetch_pkg;

  localparam int IW_DEF     = 32;
  localparam int AW_DEF     = 4;
  localparam int QDEPTH_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Opcode lives in the top five bits of a word.
  localparam logic [4:0] OPC_JMP  = 5'h01;
  localparam logic [4:0] OPC_HALT = 5'h1B;

  function automatic logic [4:0] opcode(
    input logic [31:0] w
  );
    return w[31:27];
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// fetch_queue: small sync FIFO with flush,
// carrying {pc, instr} entries to decode.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  assign dout = mem[rp];

  // Storage array, not reset; only live entries are read.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointer and occupancy tracking; flush empties the queue.
  always_ff @(posedge clk) begin
    if (sys_rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + (PW+1)'(push)
                     - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: instruction memory, PC, prefetch
// queue to decode. Optional FETCH_PERF_EN counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int IW     = IW_DEF,
  parameter int AW     = AW_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  output logic          ir_valid,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_target,
  input  logic          halt,
  output logic [AW-1:0] fetch_pc,
  output logic          halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int QW = AW + IW;

  state_t        state;
  logic [IW-1:0] imem [2**AW];
  logic [IW-1:0] rdata;
  logic [AW-1:0] rd_pc;
  logic          inflight;
  logic [CW-1:0] q_count;
  logic [QW-1:0] q_head;
  logic          q_nempty;
  logic          run;
  logic          pop;
  logic          flush;
  logic          issue;
  logic          q_push;
  logic          q_pop;
  logic [CW:0]   occ;

  // The in-flight read acts as the queue's newest
  // entry, so word 0 is visible the cycle it lands.
  assign run      = state == S_RUN;
  assign q_nempty = q_count != '0;
  assign ir_valid = q_nempty | inflight;
  assign ir       = q_nempty ? q_head[IW-1:0]
                             : rdata;
  assign ir_pc    = q_nempty ? q_head[QW-1:IW]
                             : rd_pc;
  assign pop      = ir_valid & ir_ready;
  assign q_pop    = pop & q_nempty;
  assign flush    = run & (jmp_valid | halt);
  assign q_push   = inflight & ~flush
                  & ~(pop & ~q_nempty);
  assign occ      = {1'b0, q_count}
                  + (CW+1)'(inflight)
                  - (CW+1)'(pop);
  assign issue    = run & ~load_en & ~flush
                  & (occ < (CW+1)'(QDEPTH));
  assign halted   = state == S_HALT;

  // Instruction memory write port, no reset.
  always_ff @(posedge clk) begin
    if (load_en) imem[load_addr] <= load_data;
  end

  // State, PC and the registered memory read.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      inflight <= 1'b0;
      rdata    <= '0;
      rd_pc    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rdata <= imem[fetch_pc];
        rd_pc <= fetch_pc;
      end
      unique case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN: begin
          if (halt)
            state <= S_HALT;
          else if (jmp_valid)
            fetch_pc <= jmp_target;
          else if (issue)
            fetch_pc <= fetch_pc + 1'b1;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (QW)
  ) u_queue (
    .clk     (clk),
    .sys_rst (sys_rst),
    .flush   (flush),
    .push    (q_push),
    .din     ({rd_pc, rdata}),
    .pop     (q_pop),
    .dout    (q_head),
    .count   (q_count)
  );

`ifdef FETCH_PERF_EN
  // Saturating handshake and starvation counters.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (run && ir_ready && !ir_valid
          && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: startup, stall,
// redirect, wrap, halt and reset sequences.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        ir_valid;
  logic [31:0] ir;
  logic [3:0]  ir_pc;
  logic        ir_ready;
  logic        jmp_valid;
  logic [3:0]  jmp_target;
  logic        halt;
  logic [3:0]  fetch_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .ir_valid   (ir_valid),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_ready   (ir_ready),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .halt       (halt),
    .fetch_pc   (fetch_pc),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(
    input int a
  );
    logic [31:0] w;
    unique case (a)
      0: w = 32'h0800_0005;
      1: w = 32'h1000_0001;
      2: w = 32'h0000_0000;
      3: w = 32'hD800_0000;
      default: w = 32'h5500_0000 | a;
    endcase
    return w;
  endfunction

  task automatic head(
    input string tag,
    input int    pc
  );
    chk({tag, "_v"},  ir_valid, 1'b1);
    chk({tag, "_pc"}, ir_pc, pc[3:0]);
    chk({tag, "_ir"}, ir, word(pc));
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst    = 1'b1;
    start      = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    ir_ready   = 1'b0;
    jmp_valid  = 1'b0;
    jmp_target = '0;
    halt       = 1'b0;
    tick();
    tick();
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_ir",    ir, 32'h0);
    chk("rst_irpc",  ir_pc, 4'h0);
    chk("rst_fpc",   fetch_pc, 4'h0);
    chk("rst_halted", halted, 1'b0);
    sys_rst = 1'b0;

    // load all 16 words while idle
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = i[3:0];
      load_data = word(i);
      tick();
    end
    load_en = 1'b0;
    tick();
    chk("idle_valid", ir_valid, 1'b0);

    // steady stream from PC 0
    ir_ready = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_valid", ir_valid, 1'b0);
    tick();
    head("s_pc0", 0);
    tick();
    head("s_pc1", 1);
    tick();
    head("s_pc2", 2);
    tick();
    head("s_pc3", 3);

    // backpressure: ready low five cycles
    do_reset();
    ir_ready = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("b1_valid", ir_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      head("b_hold", 0);
    end
    chk("b_fpc", fetch_pc, 4'h2);
    ir_ready = 1'b1;
    tick();
    head("b_pc1", 1);
    tick();
    head("b_pc2", 2);
    tick();
    head("b_pc3", 3);

    // redirect while PC 1 is accepted
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    head("j_pc0", 0);
    tick();
    head("j_pc1", 1);
    jmp_valid  = 1'b1;
    jmp_target = 4'hA;
    tick();
    jmp_valid = 1'b0;
    chk("j_bubble", ir_valid, 1'b0);
    chk("j_fpc", fetch_pc, 4'hA);
    tick();
    head("j_pcA", 10);
    tick();
    head("j_pcB", 11);

    // wrap from PC 14
    jmp_valid  = 1'b1;
    jmp_target = 4'hE;
    tick();
    jmp_valid = 1'b0;
    chk("w_bubble", ir_valid, 1'b0);
    tick();
    head("w_pcE", 14);
    tick();
    head("w_pcF", 15);
    tick();
    head("w_pc0", 0);
    tick();
    head("w_pc1", 1);

    // halt wins over a same-cycle jump
    halt       = 1'b1;
    jmp_valid  = 1'b1;
    jmp_target = 4'h5;
    tick();
    halt      = 1'b0;
    jmp_valid = 1'b0;
    chk("h_halted", halted, 1'b1);
    chk("h_valid", ir_valid, 1'b0);
    chk("h_fpc", fetch_pc, 4'h2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h_stay", halted, 1'b1);
      chk("h_novalid", ir_valid, 1'b0);
    end

    // reset with a full queue
    do_reset();
    chk("r_halted", halted, 1'b0);
    ir_ready = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    head("r_full", 0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("r_valid", ir_valid, 1'b0);
    chk("r_ir",    ir, 32'h0);
    chk("r_irpc",  ir_pc, 4'h0);
    chk("r_fpc",   fetch_pc, 4'h0);
    chk("r_hlt",   halted, 1'b0);
    ir_ready = 1'b1;
    tick();
    chk("r_idle", ir_valid, 1'b0);
    chk("r_idle_fpc", fetch_pc, 4'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    head("r_mem0", 0);
    tick();
    head("r_mem1", 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
